mem_access_unit: RTL and testbench

- Sits between the EXE2MEM pipeline register and the byte-addressed, big-endian data memory.
- Converts byte, halfword and word loads and stores into aligned 32-bit memory transactions.
- Sub-word stores use a two-cycle read-modify-write sequence, during which the unit stalls upstream.
- Load results are registered, sign- or zero-extended, and handed to the MEM2WB register.

---
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit between EXE2MEM and a big-endian byte-addressed data memory.
// Define MEM_ALIGN_CHECK_EN to suppress misaligned halfword/word accesses and flag them on AlignFault.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemRdData,
  output logic [31:0] MemAddr,
  output logic        MemRdEn,
  output logic        MemWrEn,
  output logic [31:0] MemWrData,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        Stall,
  output logic        AlignFault
);

  typedef enum logic {IDLE, RMW_WR} stateType;

  stateType    state;
  logic        isStore, isLoad, isWord, isHalf, inRange, misaligned, accessOk;
  logic [31:0] wordAddr, mergeWord, loadWord, mergeReg, capAddr;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign isStore  = Valid && MemWrite;
  assign isLoad   = Valid && MemRead && !MemWrite;
  assign isWord   = Size[1];
  assign isHalf   = (Size == 2'b01);
  assign inRange  = (Address < 32'(MEM_BYTES));
  assign wordAddr = {Address[31:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (isLoad || isStore) &&
                      ((isHalf && Address[0]) || (isWord && (Address[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign accessOk = inRange && !misaligned;

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    loadByte = MemRdData[7:0];
    case (Address[1:0])
      2'd0: loadByte = MemRdData[31:24];
      2'd1: loadByte = MemRdData[23:16];
      2'd2: loadByte = MemRdData[15:8];
      default: loadByte = MemRdData[7:0];
    endcase
    loadHalf = Address[1] ? MemRdData[15:0] : MemRdData[31:16];
    if (isWord)
      loadWord = MemRdData;
    else if (isHalf)
      loadWord = Unsigned ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
    else
      loadWord = Unsigned ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
  end

  always_comb begin
    mergeWord = MemRdData;
    if (isHalf) begin
      if (Address[1]) mergeWord[15:0]  = StoreData[15:0];
      else            mergeWord[31:16] = StoreData[15:0];
    end else begin
      case (Address[1:0])
        2'd0: mergeWord[31:24] = StoreData[7:0];
        2'd1: mergeWord[23:16] = StoreData[7:0];
        2'd2: mergeWord[15:8]  = StoreData[7:0];
        default: mergeWord[7:0] = StoreData[7:0];
      endcase
    end
  end

  // Enables are gated by Reset so nothing reaches memory while reset is held.
  assign MemAddr   = (state == RMW_WR) ? capAddr : wordAddr;
  assign MemWrData = (state == RMW_WR) ? mergeReg : StoreData;
  assign MemRdEn   = !Reset && (state == IDLE) && accessOk &&
                     (isLoad || (isStore && !isWord));
  assign MemWrEn   = !Reset && ((state == RMW_WR) ||
                     ((state == IDLE) && isStore && isWord && accessOk));
  assign Stall     = !Reset && (state == IDLE) && isStore && !isWord && accessOk;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      LoadData  <= '0;
      LoadValid <= 1'b0;
      mergeReg  <= '0;
      capAddr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          LoadValid <= isLoad;
          if (isLoad)
            LoadData <= accessOk ? loadWord : '0;
          if (isStore && !isWord && accessOk) begin
            mergeReg <= mergeWord;
            capAddr  <= wordAddr;
            state    <= RMW_WR;
          end
        end
        RMW_WR: begin
          LoadValid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      AlignFault <= 1'b0;
    else
      AlignFault <= (state == IDLE) && misaligned;
  end
`else
  assign AlignFault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level memory model plus directed vectors.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk = 0, Reset = 0, Valid = 0, MemRead = 0, MemWrite = 0, Unsigned = 0;
  logic [1:0]  Size = 0;
  logic [31:0] Address = 0, StoreData = 0;
  logic [31:0] MemRdData, MemAddr, MemWrData, LoadData;
  logic        MemRdEn, MemWrEn, LoadValid, Stall, AlignFault;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .Reset(Reset), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .Address(Address), .StoreData(StoreData),
    .MemRdData(MemRdData), .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
    .MemWrData(MemWrData), .LoadData(LoadData), .LoadValid(LoadValid), .Stall(Stall),
    .AlignFault(AlignFault)
  );

  // Physical data memory the DUT talks to.
  logic [31:0] tbMem [0:255];
  assign MemRdData = tbMem[MemAddr[9:2]];
  always @(posedge clk) if (MemWrEn) tbMem[MemAddr[9:2]] <= MemWrData;

  // Reference model state: byte array plus expected outputs for this and the next cycle.
  logic [7:0]  refMem [0:MEM_BYTES-1];
  int          testsRun = 0, failCount = 0;
  bit          checkEn = 0;
  logic        eRd = 0, eWr = 0, eSt = 0, eLV = 0, eAF = 0, nLV = 0, nAF = 0, rmwPending = 0;
  logic [31:0] eAddr = 0, eWrData = 0, eLD = 0, nLD = 0, pendAddr = 0, pendWord = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refWord(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'd3;
    return {refMem[b], refMem[b+1], refMem[b+2], refMem[b+3]};
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] hb;
    if (sz == 2'b00) begin
      b = refMem[a];
      return uns ? 32'(b) : 32'($signed(b));
    end else if (sz == 2'b01) begin
      hb = a & ~32'd1;
      h  = {refMem[hb], refMem[hb+1]};
      return uns ? 32'(h) : 32'($signed(h));
    end
    return refWord(a);
  endfunction

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("MemRdEn", MemRdEn, eRd);
      checkOutput("MemWrEn", MemWrEn, eWr);
      checkOutput("Stall", Stall, eSt);
      checkOutput("LoadValid", LoadValid, eLV);
      checkOutput("AlignFault", AlignFault, eAF);
      if (eLV) checkOutput("LoadData", LoadData, eLD);
      if (eRd || eWr) checkOutput("MemAddr", MemAddr, eAddr);
      if (eWr) checkOutput("MemWrData", MemWrData, eWrData);
    end
  end

  task automatic driveCycle(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, sd);
    logic        inRange, mis, ok;
    logic [31:0] aligned, hb;
    @(posedge clk); #1;
    Valid = v; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
    Address = addr; StoreData = sd;
    eLV = nLV; eLD = nLD; eAF = nAF;
    eRd = 0; eWr = 0; eSt = 0; eAddr = 0; eWrData = 0; nLV = 0; nAF = 0;
    if (rmwPending) begin
      eWr = 1; eAddr = pendAddr; eWrData = pendWord; rmwPending = 0;
    end else if (v && (rd || wr)) begin
      inRange = (addr < MEM_BYTES);
      mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
`endif
      ok = inRange && !mis;
      nAF = mis;
      aligned = addr & ~32'd3;
      if (wr) begin
        if (ok && sz[1]) begin
          eWr = 1; eAddr = aligned; eWrData = sd;
          for (int i = 0; i < 4; i++) refMem[aligned+i] = sd[31-8*i -: 8];
        end else if (ok) begin
          eRd = 1; eSt = 1; eAddr = aligned;
          if (sz == 2'b00) refMem[addr] = sd[7:0];
          else begin
            hb = addr & ~32'd1;
            refMem[hb] = sd[15:8]; refMem[hb+1] = sd[7:0];
          end
          pendAddr = aligned; pendWord = refWord(addr); rmwPending = 1;
        end
      end else begin
        nLV = 1; eRd = ok; eAddr = aligned;
        nLD = ok ? refLoad(sz, uns, addr) : 32'h0;
      end
    end
  endtask

  // Sub-word stores keep their inputs held through the RMW cycle, as a stalled upstream would.
  task automatic applyStimulus(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, sd);
    driveCycle(v, rd, wr, sz, uns, addr, sd);
    if (rmwPending) driveCycle(v, rd, wr, sz, uns, addr, sd);
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
  endtask

  task automatic loadCheck(input string name, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(1, 1, 0, sz, uns, addr, 32'h0);
    applyIdle();
    checkOutput(name, LoadData, expected);
    checkOutput({name, "Valid"}, LoadValid, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbMem[i] = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'h0;

    #1 Reset = 1;
    Valid = 1; MemWrite = 1; Size = 2'b10; Address = 32'h10; StoreData = 32'h12345678;
    #2;
    checkOutput("rstLoadData", LoadData, 32'h0);
    checkOutput("rstLoadValid", LoadValid, 32'h0);
    checkOutput("rstAlignFault", AlignFault, 32'h0);
    checkOutput("rstMemWrEn", MemWrEn, 32'h0);
    checkOutput("rstMemRdEn", MemRdEn, 32'h0);
    checkOutput("rstStall", Stall, 32'h0);
    Valid = 0; MemWrite = 0;
    @(negedge clk); Reset = 0;
    #1 checkEn = 1;

    applyStimulus(1, 0, 1, 2'b10, 0, 32'h10, 32'h11223344);
    loadCheck("lbSigned13", 2'b00, 0, 32'h13, 32'h00000044);
    loadCheck("lhSigned10", 2'b01, 0, 32'h10, 32'h00001122);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h10, 32'h000000FF);
    loadCheck("lbSigned10", 2'b00, 0, 32'h10, 32'hFFFFFFFF);
    loadCheck("lbUnsigned10", 2'b00, 1, 32'h10, 32'h000000FF);

    applyStimulus(1, 0, 1, 2'b10, 0, 32'h10, 32'h11223344);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h12, 32'h123456AB);
    applyIdle();
    checkOutput("rmwByteMem", tbMem[4], 32'h1122AB44);
    loadCheck("lhUnsigned12", 2'b01, 1, 32'h12, 32'h0000AB44);
    loadCheck("lhSigned12", 2'b01, 0, 32'h12, 32'hFFFFAB44);

    applyStimulus(1, 0, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF);
    loadCheck("lwAfterSw", 2'b10, 0, 32'h40, 32'hDEADBEEF);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h42, 32'hFFFF1234);
    applyIdle();
    checkOutput("rmwHalfMem", tbMem[16], 32'hDEAD1234);
    loadCheck("lwSize3", 2'b11, 0, 32'h40, 32'hDEAD1234);
    applyStimulus(1, 1, 1, 2'b10, 0, 32'h44, 32'h55AA55AA);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h44, 32'h0);
    loadCheck("lwStorePriority", 2'b10, 0, 32'h44, 32'h55AA55AA);

    loadCheck("oorLoad", 2'b10, 0, 32'd1024, 32'h0);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h800, 32'h99);
    applyIdle();
    checkOutput("oorStoreDropped", tbMem[0], 32'h0);

    applyStimulus(1, 0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D);
    loadCheck("lwBeforeReset", 2'b10, 0, 32'h44, 32'h55AA55AA);

    checkEn = 0;
    @(posedge clk); #1;
    Valid = 1; MemWrite = 1; MemRead = 0; Size = 2'b00; Address = 32'h20; StoreData = 32'h5A;
    #3 checkOutput("rmwStallBeforeReset", Stall, 32'd1);
    @(posedge clk); #1;
    checkOutput("rmwWrEnBeforeReset", MemWrEn, 32'd1);
    Valid = 0; MemWrite = 0;
    #2 Reset = 1;
    #1;
    checkOutput("midRmwMemWrEn", MemWrEn, 32'h0);
    checkOutput("midRmwMemRdEn", MemRdEn, 32'h0);
    checkOutput("midRmwStall", Stall, 32'h0);
    checkOutput("midRmwLoadValid", LoadValid, 32'h0);
    checkOutput("midRmwLoadData", LoadData, 32'h0);
    checkOutput("midRmwAlignFault", AlignFault, 32'h0);
    @(posedge clk); #1 Reset = 0;
    checkOutput("resetAbandonsRmw", tbMem[8], 32'hCAFEF00D);
    eRd = 0; eWr = 0; eSt = 0; eLV = 0; eAF = 0; nLV = 0; nAF = 0; rmwPending = 0;
    checkEn = 1;
    loadCheck("lwAfterReset", 2'b10, 0, 32'h20, 32'hCAFEF00D);

    applyStimulus(1, 0, 1, 2'b01, 0, 32'h21, 32'h7788);
    applyIdle();
    applyIdle();
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("misalignedHalfMem", tbMem[8], 32'hCAFEF00D);
    loadCheck("misalignedWordLoad", 2'b10, 0, 32'h22, 32'h0);
`else
    checkOutput("misalignedHalfMem", tbMem[8], 32'h7788F00D);
    loadCheck("misalignedWordLoad", 2'b10, 0, 32'h22, 32'h7788F00D);
`endif
    applyIdle();
    applyIdle();
    checkEn = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
